// File: rtl/render_pkg.sv
// Shared rendering types and screen constants used by the buffer clear engine
// and its address generator.
package render_pkg;

  localparam int H_RES = 320;
  localparam int V_RES = 240;

  typedef logic [8:0] x_t;
  typedef logic [7:0] y_t;

  typedef enum logic {
    CLR_FULL = 1'b0,
    CLR_RECT = 1'b1
  } clear_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FULL = 2'd1,
    RECT = 2'd2,
    DONE = 2'd3
  } clear_state_e;

endpackage

// File: rtl/clear_addr_gen.sv
// Address sequencer for the clear engine: linear sweep or rectangle scan with a
// row-base accumulator, plus a flag marking the final pixel.
module clear_addr_gen #(
  parameter int H_RES       = 320,
  parameter int CLEAR_COUNT = 76800,
  parameter int ADDR_W      = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic              full_mode,
  input  logic [8:0]        x0,
  input  logic [8:0]        x1,
  input  logic [7:0]        y0,
  input  logic [7:0]        y1,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  import render_pkg::*;

  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);
  localparam logic [ADDR_W-1:0] LAST_LIN = ADDR_W'(CLEAR_COUNT - 1);

  x_t                x_q, x0_q, x1_q;
  y_t                y_q, y1_q;
  logic              full_q;
  logic [ADDR_W-1:0] row_base_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] start_base;

  // Constant-coefficient product: reduces to shift-and-add, used only at load.
  assign start_base = ADDR_W'(y0) * ROW_STEP;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q        <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      y_q        <= '0;
      y1_q       <= '0;
      full_q     <= 1'b0;
      row_base_q <= '0;
      addr_q     <= '0;
    end else if (load) begin
      x_q        <= x0;
      x0_q       <= x0;
      x1_q       <= x1;
      y_q        <= y0;
      y1_q       <= y1;
      full_q     <= full_mode;
      row_base_q <= full_mode ? '0 : start_base;
      addr_q     <= full_mode ? '0 : start_base + ADDR_W'(x0);
    end else if (advance) begin
      if (full_q) begin
        addr_q <= addr_q + ADDR_W'(1);
      end else if (x_q == x1_q) begin
        // Row wrap lands directly on the next row's first pixel, no bubble.
        x_q        <= x0_q;
        y_q        <= y_q + 8'd1;
        row_base_q <= row_base_q + ROW_STEP;
        addr_q     <= row_base_q + ROW_STEP + ADDR_W'(x0_q);
      end else begin
        x_q    <= x_q + 9'd1;
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  assign addr = addr_q;
  assign last = full_q ? (addr_q == LAST_LIN) : ((x_q == x1_q) && (y_q == y1_q));

endmodule

// File: rtl/buffer_clear_engine.sv
// Multi-channel BRAM clear engine: sweeps a whole buffer or a screen rectangle,
// writing latched per-channel clear values, with stall and abort support.
module buffer_clear_engine #(
  parameter int H_RES       = 320,
  parameter int V_RES       = 240,
  parameter int NUM_CH      = 2,
  parameter int DATA_W      = 12,
  parameter int ADDR_W      = 17,
  parameter int CLEAR_COUNT = H_RES * V_RES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic                     i_mode,
  input  logic [8:0]               i_x0,
  input  logic [8:0]               i_x1,
  input  logic [7:0]               i_y0,
  input  logic [7:0]               i_y1,
  input  logic [NUM_CH-1:0]        i_ch_en,
  input  logic [NUM_CH*DATA_W-1:0] i_clear_val,
  input  logic                     i_stall,
  input  logic                     i_abort,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [NUM_CH-1:0]        o_we,
  output logic [ADDR_W-1:0]        o_addr,
  output logic [NUM_CH*DATA_W-1:0] o_data
);
  import render_pkg::*;

  localparam x_t X_MAX = x_t'(H_RES - 1);
  localparam y_t Y_MAX = y_t'(V_RES - 1);

  clear_state_e              state_q, state_d;
  logic [NUM_CH-1:0]         ch_en_q;
  logic [NUM_CH*DATA_W-1:0]  data_q;
  x_t                        x1_clamp;
  y_t                        y1_clamp;
  logic                      rect_empty;
  logic                      accept;
  logic                      sweeping;
  logic                      active_write;
  logic                      gen_load;
  logic                      gen_advance;
  logic                      gen_last;
  logic [ADDR_W-1:0]         gen_addr;

  assign x1_clamp   = (i_x1 > X_MAX) ? X_MAX : i_x1;
  assign y1_clamp   = (i_y1 > Y_MAX) ? Y_MAX : i_y1;
  assign rect_empty = (i_x0 > x1_clamp) || (i_y0 > y1_clamp);
  assign accept     = (state_q == IDLE) && i_start && !i_abort;
  assign sweeping   = (state_q == FULL) || (state_q == RECT);

  always_comb begin
    state_d     = state_q;
    gen_load    = 1'b0;
    gen_advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          gen_load = 1'b1;
          if (clear_mode_e'(i_mode) == CLR_RECT) begin
            state_d = rect_empty ? DONE : RECT;
          end else begin
            state_d = FULL;
          end
        end
      end
      FULL, RECT: begin
        // Abort wins over both a stall and the final write.
        if (i_abort) begin
          state_d = IDLE;
        end else if (!i_stall) begin
          if (gen_last) begin
            state_d = DONE;
          end else begin
            gen_advance = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ch_en_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ch_en_q <= i_ch_en;
        data_q  <= i_clear_val;
      end
    end
  end

  clear_addr_gen #(
    .H_RES       (H_RES),
    .CLEAR_COUNT (CLEAR_COUNT),
    .ADDR_W      (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (gen_load),
    .advance   (gen_advance),
    .full_mode (clear_mode_e'(i_mode) == CLR_FULL),
    .x0        (i_x0),
    .x1        (x1_clamp),
    .y0        (i_y0),
    .y1        (y1_clamp),
    .addr      (gen_addr),
    .last      (gen_last)
  );

  assign active_write = sweeping && !i_stall && !i_abort;
  assign o_we         = ch_en_q & {NUM_CH{active_write}};
  assign o_addr       = gen_addr;
  assign o_data       = data_q;
  assign o_busy       = (state_q != IDLE);
  assign o_done       = (state_q == DONE);

endmodule

// File: tb/tb_buffer_clear_engine.sv
// Scoreboard bench for buffer_clear_engine: each sweep pushes a cycle-accurate
// list of expected output events that a negedge monitor pops and compares.
module tb_buffer_clear_engine;

  localparam int HR = 320;
  localparam int VR = 240;
  localparam int CC = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_mode = 1'b0;
  logic [8:0]  i_x0 = '0, i_x1 = '0;
  logic [7:0]  i_y0 = '0, i_y1 = '0;
  logic [1:0]  i_ch_en = '0;
  logic [23:0] i_clear_val = '0;
  logic        i_stall = 1'b0;
  logic        i_abort = 1'b0;
  logic        o_busy, o_done;
  logic [1:0]  o_we;
  logic [16:0] o_addr;
  logic [23:0] o_data;

  typedef struct {
    int          cyc;
    logic [1:0]  we;
    logic        chk_addr;
    logic [16:0] addr;
    logic [23:0] data;
    logic        done;
    logic        busy;
  } ev_t;

  ev_t sb[$];
  ev_t cur;
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  buffer_clear_engine #(
    .H_RES(HR), .V_RES(VR), .NUM_CH(2), .DATA_W(12), .ADDR_W(17), .CLEAR_COUNT(CC)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_mode(i_mode),
    .i_x0(i_x0), .i_x1(i_x1), .i_y0(i_y0), .i_y1(i_y1),
    .i_ch_en(i_ch_en), .i_clear_val(i_clear_val),
    .i_stall(i_stall), .i_abort(i_abort),
    .o_busy(o_busy), .o_done(o_done), .o_we(o_we), .o_addr(o_addr), .o_data(o_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void pushEv(int c, logic [1:0] we, logic chk, int addr,
                                 logic [23:0] d, logic done, logic busy);
    ev_t e;
    e.cyc = c; e.we = we; e.chk_addr = chk; e.addr = 17'(addr);
    e.data = d; e.done = done; e.busy = busy;
    sb.push_back(e);
  endfunction

  // Monitor: compare the event due this cycle, otherwise the engine must be quiet.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      cur = sb.pop_front();
      checkOutput($sformatf("we@%0d", cyc),   32'(o_we),   32'(cur.we));
      checkOutput($sformatf("busy@%0d", cyc), 32'(o_busy), 32'(cur.busy));
      checkOutput($sformatf("done@%0d", cyc), 32'(o_done), 32'(cur.done));
      checkOutput($sformatf("data@%0d", cyc), 32'(o_data), 32'(cur.data));
      if (cur.chk_addr) checkOutput($sformatf("addr@%0d", cyc), 32'(o_addr), 32'(cur.addr));
    end else if (!rst && (o_we != 2'b00 || o_done)) begin
      checkOutput($sformatf("spurious@%0d", cyc), 32'({o_done, o_we}), 32'd0);
    end
  end

  // Drives one sweep and pushes the independently modelled event timeline.
  task automatic applyStimulus(input logic mode, input int x0, input int x1,
                               input int y0, input int y1, input logic [1:0] mask,
                               input logic [23:0] vals, input int stall_after,
                               input int stall_len, input int abort_at, input bit restart);
    int addrs[$];
    int t, t0, x1c, y1c;
    int stall_lo, stall_hi, abort_cyc;
    bit aborted;
    stall_lo = -1; stall_hi = -1; abort_cyc = -1; aborted = 0;
    i_mode = mode; i_x0 = 9'(x0); i_x1 = 9'(x1); i_y0 = 8'(y0); i_y1 = 8'(y1);
    i_ch_en = mask; i_clear_val = vals; i_start = 1'b1;
    t0 = cyc + 1;
    if (mode == 1'b0) begin
      for (int i = 0; i < CC; i++) addrs.push_back(i);
    end else begin
      x1c = (x1 > HR - 1) ? HR - 1 : x1;
      y1c = (y1 > VR - 1) ? VR - 1 : y1;
      if (x0 <= x1c && y0 <= y1c)
        for (int y = y0; y <= y1c; y++)
          for (int x = x0; x <= x1c; x++) addrs.push_back(y * HR + x);
    end
    t = t0;
    for (int i = 0; i < addrs.size(); i++) begin
      if (i == stall_after && stall_len > 0) begin
        stall_lo = t;
        for (int s = 0; s < stall_len; s++) begin
          pushEv(t, 2'b00, 1'b1, addrs[i], vals, 1'b0, 1'b1);
          t++;
        end
        stall_hi = t - 1;
      end
      if (i == abort_at) begin
        abort_cyc = t;
        pushEv(t, 2'b00, 1'b0, 0, vals, 1'b0, 1'b1);
        t++;
        aborted = 1;
        break;
      end
      pushEv(t, mask, 1'b1, addrs[i], vals, 1'b0, 1'b1);
      t++;
    end
    if (!aborted) begin
      pushEv(t, 2'b00, 1'b0, 0, vals, 1'b1, 1'b1);
      t++;
    end
    pushEv(t, 2'b00, 1'b0, 0, vals, 1'b0, 1'b0);
    while (cyc <= t) begin
      @(posedge clk); #1;
      i_start     = restart && (cyc == t0 + 3);
      i_stall     = (cyc >= stall_lo) && (cyc <= stall_hi);
      i_abort     = (cyc == abort_cyc);
      i_ch_en     = ~mask;
      i_clear_val = ~vals;
    end
    i_start = 1'b0; i_stall = 1'b0; i_abort = 1'b0;
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_done", 32'(o_done), 32'd0);
    checkOutput("rst_we",   32'(o_we),   32'd0);
    checkOutput("rst_addr", 32'(o_addr), 32'd0);
    checkOutput("rst_data", 32'(o_data), 32'd0);
    @(posedge clk); #1;

    $display("[TB] full sweep");
    applyStimulus(1'b0, 0, 0, 0, 0, 2'b11, {12'h0FF, 12'h000}, -1, 0, -1, 0);
    $display("[TB] rectangle (2,1)-(4,2)");
    applyStimulus(1'b1, 2, 4, 1, 2, 2'b11, {12'hABC, 12'h123}, -1, 0, -1, 0);
    $display("[TB] full sweep with stall");
    applyStimulus(1'b0, 0, 0, 0, 0, 2'b11, {12'h555, 12'hAAA}, 3, 3, -1, 0);
    $display("[TB] abort on fifth write, then restart");
    applyStimulus(1'b0, 0, 0, 0, 0, 2'b11, {12'h111, 12'h222}, -1, 0, 4, 0);
    applyStimulus(1'b0, 0, 0, 0, 0, 2'b01, {12'h333, 12'h444}, -1, 0, -1, 0);
    $display("[TB] abort on final write");
    applyStimulus(1'b0, 0, 0, 0, 0, 2'b11, {12'h777, 12'h888}, -1, 0, 9, 0);
    $display("[TB] empty and clamped rectangles");
    applyStimulus(1'b1, 10, 5, 0, 3, 2'b11, {12'hF00, 12'h00F}, -1, 0, -1, 0);
    applyStimulus(1'b1, 316, 400, 238, 239, 2'b11, {12'h0F0, 12'hF0F}, -1, 0, -1, 0);
    $display("[TB] mask 10 with restart mid-sweep");
    applyStimulus(1'b0, 0, 0, 0, 0, 2'b10, {12'hDEF, 12'h987}, -1, 0, -1, 1);
    $display("[TB] zero mask rectangle stalled across row wrap");
    applyStimulus(1'b1, 0, 2, 0, 1, 2'b00, {12'h246, 12'h135}, 3, 2, -1, 0);

    $display("[TB] start with abort in idle");
    i_mode = 1'b0; i_ch_en = 2'b11; i_start = 1'b1; i_abort = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0; i_abort = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("start_abort_busy", 32'(o_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
